// File: rtl/mux_condt.sv
// 4:1 WIDTH-bit conditional multiplexer with a combinational output and a
// registered shadow stage (data, select, select-change flag).
module mux_condt #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic [1:0]       sel_q,
  output logic             sel_change
);

  logic [WIDTH-1:0] out_d;
  logic [1:0]       sel_d;
  logic             sel_change_d;
  logic             sel_change_q;

  // An X/Z select propagates as X through the ?: chain; no default data is substituted.
  assign out = (select == 2'b00) ? in0 :
               (select == 2'b01) ? in1 :
               (select == 2'b10) ? in2 : in3;

  assign sel_change = sel_change_q;

  // Next-state for the shadow stage; reset wins over a simultaneous select change.
  always_comb begin
    out_d        = {WIDTH{1'b0}};
    sel_d        = 2'b00;
    sel_change_d = 1'b0;
    if (rst) begin
      out_d        = {WIDTH{1'b0}};
      sel_d        = 2'b00;
      sel_change_d = 1'b0;
    end else begin
      out_d        = out;
      sel_d        = select;
      sel_change_d = (select != sel_q);
    end
  end

  // Shadow stage registers.
  always_ff @(posedge clk) begin
    out_q        <= out_d;
    sel_q        <= sel_d;
    sel_change_q <= sel_change_d;
  end

endmodule

// File: tb/tb_mux_condt.sv
// Self-checking bench for mux_condt: directed steps followed by randomized
// traffic, checked against an array-indexed reference model (WIDTH=2 and 8).
module tb_mux_condt;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic [1:0] select;
  logic [1:0] din2 [4];
  logic [7:0] din8 [4];

  logic [1:0] out2, out_q2, sel_q2;
  logic       sel_change2;
  logic [7:0] out8, out_q8;
  logic [1:0] sel_q8;
  logic       sel_change8;

  int n_cmp;
  int n_fail;

  // Reference-model state: the select value sampled at the last edge.
  logic [1:0] m_sel_q;
  logic [7:0] e_out_q2, e_out_q8;
  logic       e_chg;

  mux_condt #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .in0(din2[0]), .in1(din2[1]), .in2(din2[2]), .in3(din2[3]),
    .select(select), .out(out2), .out_q(out_q2), .sel_q(sel_q2),
    .sel_change(sel_change2)
  );

  mux_condt #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in0(din8[0]), .in1(din8[1]), .in2(din8[2]), .in3(din8[3]),
    .select(select), .out(out8), .out_q(out_q8), .sel_q(sel_q8),
    .sel_change(sel_change8)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Predict the registered outputs from current inputs, take one edge, then check.
  task automatic tick(input string tag);
    logic [1:0] e_sel;
    if (rst) begin
      e_out_q2 = 8'd0;
      e_out_q8 = 8'd0;
      e_sel    = 2'b00;
      e_chg    = 1'b0;
    end else begin
      e_out_q2 = {6'd0, din2[select]};
      e_out_q8 = din8[select];
      e_sel    = select;
      e_chg    = (select != m_sel_q);
    end
    m_sel_q = e_sel;
    @(posedge clk);
    #1;
    chk({tag, ".out_q2"}, out_q2, e_out_q2);
    chk({tag, ".sel_q2"}, {6'd0, sel_q2}, {6'd0, e_sel});
    chk({tag, ".chg2"}, {7'd0, sel_change2}, {7'd0, e_chg});
    chk({tag, ".out_q8"}, out_q8, e_out_q8);
    chk({tag, ".sel_q8"}, {6'd0, sel_q8}, {6'd0, e_sel});
    chk({tag, ".chg8"}, {7'd0, sel_change8}, {7'd0, e_chg});
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    clk_en  = 1'b0;
    rst     = 1'b0;
    m_sel_q = 2'b00;
    din2[0] = 2'b10; din2[1] = 2'b00; din2[2] = 2'b01; din2[3] = 2'b11;
    for (int i = 0; i < 4; i++) din8[i] = 8'(i * 8'h11 + 8'h05);

    // Combinational path with no clock at all.
    select = 2'b00; #10; chk("nc.sel00", {6'd0, out2}, 8'h02);
    select = 2'b01; #10; chk("nc.sel01", {6'd0, out2}, 8'h00);
    select = 2'b10; #10; chk("nc.sel10", {6'd0, out2}, 8'h01);
    select = 2'b11; #10; chk("nc.sel11", {6'd0, out2}, 8'h03);
    select = 2'b10; din2[2] = 2'b11; #1;
    chk("nc.follow", {6'd0, out2}, 8'h03);
    din2[2] = 2'b01; #1;

    // Reset held for two edges; out keeps tracking.
    clk_en = 1'b1;
    rst    = 1'b1;
    tick("rst1");
    tick("rst2");
    chk("rst.out_q", {6'd0, out_q2}, 8'h00);
    chk("rst.out", {6'd0, out2}, 8'h01);

    // Release with select=00, then 11, then hold.
    rst = 1'b0; select = 2'b00;
    tick("rel0");
    chk("rel0.out_q", {6'd0, out_q2}, 8'h02);
    chk("rel0.chg", {7'd0, sel_change2}, 8'h00);
    select = 2'b11;
    tick("rel1");
    chk("rel1.out_q", {6'd0, out_q2}, 8'h03);
    chk("rel1.chg", {7'd0, sel_change2}, 8'h01);
    tick("hold");
    chk("hold.chg", {7'd0, sel_change2}, 8'h00);

    // Reset coincident with a select change: reset wins.
    rst = 1'b1; select = 2'b01;
    tick("rstchg");
    chk("rstchg.chg", {7'd0, sel_change2}, 8'h00);
    chk("rstchg.out", {6'd0, out2}, 8'h00);

    // Randomized traffic with occasional resets and held selects.
    rst = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) != 0) select = 2'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) begin
        din2[i] = 2'($urandom);
        din8[i] = 8'($urandom);
      end
      rst = ($urandom_range(0, 9) == 0);
      #1;
      chk("rnd.out2", {6'd0, out2}, {6'd0, din2[select]});
      chk("rnd.out8", out8, din8[select]);
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
